ad9866_emu: RTL

Synthesizable codec-side emulator of the AD9866 full-duplex 6-bit nibble interface. It receives the FPGA's multiplexed TX nibble bus, including the fast-LNA PGA gain escape on `ad9866_pga5`, and reassembles 12-bit TX samples and gain updates. It drives the RX nibble bus with `ad9866_rxsync` framing from a 12-bit sample source. It sits opposite the AD9866 driver in loopback builds and hardware-less benches, in place of the physical codec.

---
 rtl/ad9866_emu_if.sv | 28 ++
 rtl/ad9866_emu.sv | 92 +++++++++
 2 files changed

// File: rtl/ad9866_emu_if.sv
// AD9866 6-bit nibble bus between FPGA driver (master) and codec (slave).
// Carries the TX nibble/sync/quiet/PGA pins and the RX nibble/sync pins.
interface ad9866_emu_if;
  logic [5:0] ad9866_tx;
  logic       ad9866_txsync;
  logic       ad9866_txquiet_n;
  logic       ad9866_pga5;
  logic [5:0] ad9866_rx;
  logic       ad9866_rxsync;

  modport master (
    output ad9866_tx,
    output ad9866_txsync,
    output ad9866_txquiet_n,
    output ad9866_pga5,
    input  ad9866_rx,
    input  ad9866_rxsync
  );

  modport slave (
    input  ad9866_tx,
    input  ad9866_txsync,
    input  ad9866_txquiet_n,
    input  ad9866_pga5,
    output ad9866_rx,
    output ad9866_rxsync
  );
endinterface

// File: rtl/ad9866_emu.sv
// Codec-side AD9866 nibble interface emulator: TX reassembly, PGA escape,
// framing error count and free-running RX nibble framing.
module ad9866_emu #(
  parameter bit         LOOPBACK  = 1'b0,
  parameter logic [5:0] GAIN_INIT = 6'h1f
) (
  input  logic        clk,
  input  logic        rst_n,
  ad9866_emu_if.slave bus,
  input  logic [11:0] rx_word,
  output logic        rx_strobe,
  output logic [11:0] tx_word,
  output logic        tx_valid,
  output logic [5:0]  gain,
  output logic        gain_update,
  output logic [7:0]  frame_err
);

  logic [5:0]  msb_hold;
  logic        msb_ok;
  logic [5:0]  rx_lsb;
  logic [5:0]  rx_q;
  logic        rxsync_q;
  logic        rxph;
  logic [11:0] rx_src;
  logic        tx_done;
  logic        tx_err;
  logic        sync;
  logic        quiet_n;
  logic        pga5;

  assign sync    = bus.ad9866_txsync;
  assign quiet_n = bus.ad9866_txquiet_n;
  assign pga5    = bus.ad9866_pga5;

  assign bus.ad9866_rx     = rx_q;
  assign bus.ad9866_rxsync = rxsync_q;

  always_comb begin
    rx_src  = LOOPBACK ? tx_word : rx_word;
    tx_done = sync & quiet_n & ~pga5 & msb_ok;
    tx_err  = sync & quiet_n & (~msb_ok | pga5);
  end

  // Quiet, PGA and sync cycles all leave no pending MSB behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_hold    <= '0;
      msb_ok      <= 1'b0;
      tx_word     <= '0;
      tx_valid    <= 1'b0;
      gain        <= GAIN_INIT;
      gain_update <= 1'b0;
      frame_err   <= '0;
    end else begin
      if (!pga5 && !sync)
        msb_hold <= bus.ad9866_tx;
      msb_ok   <= quiet_n & ~pga5 & ~sync;
      tx_valid <= tx_done;
      if (tx_done)
        tx_word <= {msb_hold, bus.ad9866_tx};
      gain_update <= pga5;
      if (pga5)
        gain <= bus.ad9866_tx;
      if (tx_err && frame_err != 8'hff)
        frame_err <= frame_err + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxph      <= 1'b0;
      rx_lsb    <= '0;
      rx_q      <= '0;
      rxsync_q  <= 1'b0;
      rx_strobe <= 1'b0;
    end else begin
      rxph <= ~rxph;
      if (!rxph) begin
        rx_q      <= rx_src[11:6];
        rxsync_q  <= 1'b0;
        rx_lsb    <= rx_src[5:0];
        rx_strobe <= 1'b1;
      end else begin
        rx_q      <= rx_lsb;
        rxsync_q  <= 1'b1;
        rx_strobe <= 1'b0;
      end
    end
  end

endmodule
